// File: rtl/st7735s_init_sequencer.sv
// rtl/st7735s_init_sequencer.sv - ST7735S init/window command sequencer
// Streams {dc,byte} words to an SPI byte master with per-command ms delays.
module st7735s_init_sequencer #(
  parameter int          WIDTH          = 160,
  parameter int          HEIGHT         = 120,
  parameter int          X_OFFSET       = 0,
  parameter int          Y_OFFSET       = 0,
  parameter logic [7:0]  MADCTL_VAL     = 8'h60,
  parameter logic [7:0]  COLMOD_VAL     = 8'h06,
  parameter int          CLKS_PER_MS    = 100000,
  parameter int          DLY_SWRESET_MS = 150,
  parameter int          DLY_SLPOUT_MS  = 255,
  parameter int          DLY_DISPON_MS  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        win_req,
  input  logic [15:0] win_x0,
  input  logic [15:0] win_x1,
  input  logic [15:0] win_y0,
  input  logic [15:0] win_y1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_dc,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        init_done,
  output logic [4:0]  seq_index
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE} state_t;

  localparam logic [15:0] X_START = 16'(X_OFFSET);
  localparam logic [15:0] X_END   = 16'(X_OFFSET + WIDTH - 1);
  localparam logic [15:0] Y_START = 16'(Y_OFFSET);
  localparam logic [15:0] Y_END   = 16'(Y_OFFSET + HEIGHT - 1);

  localparam logic [31:0] CYC_SWRESET = 32'(DLY_SWRESET_MS) * 32'(CLKS_PER_MS);
  localparam logic [31:0] CYC_SLPOUT  = 32'(DLY_SLPOUT_MS) * 32'(CLKS_PER_MS);
  localparam logic [31:0] CYC_DISPON  = 32'(DLY_DISPON_MS) * 32'(CLKS_PER_MS);

  state_t      state;
  logic        win_mode;
  logic [4:0]  index;
  logic [31:0] wait_cnt;
  logic [15:0] wx0, wx1, wy0, wy1;

  logic        ent_dc;
  logic [7:0]  ent_data;
  logic [31:0] ent_cyc;
  logic [4:0]  last_index;

  assign seq_index  = index;
  assign last_index = win_mode ? 5'd10 : 5'd19;

  // Table lookup for the entry at the current index in the active table.
  always_comb begin
    ent_dc   = 1'b0;
    ent_data = 8'h00;
    ent_cyc  = 32'd0;
    if (win_mode) begin
      case (index)
        5'd0:  ent_data = 8'h2A;
        5'd1:  begin ent_dc = 1'b1; ent_data = wx0[15:8]; end
        5'd2:  begin ent_dc = 1'b1; ent_data = wx0[7:0];  end
        5'd3:  begin ent_dc = 1'b1; ent_data = wx1[15:8]; end
        5'd4:  begin ent_dc = 1'b1; ent_data = wx1[7:0];  end
        5'd5:  ent_data = 8'h2B;
        5'd6:  begin ent_dc = 1'b1; ent_data = wy0[15:8]; end
        5'd7:  begin ent_dc = 1'b1; ent_data = wy0[7:0];  end
        5'd8:  begin ent_dc = 1'b1; ent_data = wy1[15:8]; end
        5'd9:  begin ent_dc = 1'b1; ent_data = wy1[7:0];  end
        5'd10: ent_data = 8'h2C;
        default: ;
      endcase
    end else begin
      case (index)
        5'd0:  begin ent_data = 8'h01; ent_cyc = CYC_SWRESET; end
        5'd1:  begin ent_data = 8'h11; ent_cyc = CYC_SLPOUT;  end
        5'd2:  ent_data = 8'h3A;
        5'd3:  begin ent_dc = 1'b1; ent_data = COLMOD_VAL; end
        5'd4:  ent_data = 8'h36;
        5'd5:  begin ent_dc = 1'b1; ent_data = MADCTL_VAL; end
        5'd6:  ent_data = 8'h20;
        5'd7:  ent_data = 8'h13;
        5'd8:  ent_data = 8'h2A;
        5'd9:  begin ent_dc = 1'b1; ent_data = X_START[15:8]; end
        5'd10: begin ent_dc = 1'b1; ent_data = X_START[7:0];  end
        5'd11: begin ent_dc = 1'b1; ent_data = X_END[15:8];   end
        5'd12: begin ent_dc = 1'b1; ent_data = X_END[7:0];    end
        5'd13: ent_data = 8'h2B;
        5'd14: begin ent_dc = 1'b1; ent_data = Y_START[15:8]; end
        5'd15: begin ent_dc = 1'b1; ent_data = Y_START[7:0];  end
        5'd16: begin ent_dc = 1'b1; ent_data = Y_END[15:8];   end
        5'd17: begin ent_dc = 1'b1; ent_data = Y_END[7:0];    end
        5'd18: begin ent_data = 8'h29; ent_cyc = CYC_DISPON; end
        5'd19: ent_data = 8'h2C;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_dc    <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
      init_done <= 1'b0;
      index     <= 5'd0;
      win_mode  <= 1'b0;
      wait_cnt  <= 32'd0;
      wx0       <= 16'h0000;
      wx1       <= 16'h0000;
      wy0       <= 16'h0000;
      wy1       <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            index    <= 5'd0;
            win_mode <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state     <= S_LOAD;
            index     <= 5'd0;
            win_mode  <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
          end else if (win_req) begin
            state    <= S_LOAD;
            index    <= 5'd0;
            win_mode <= 1'b1;
            busy     <= 1'b1;
            wx0      <= win_x0 + X_START;
            wx1      <= win_x1 + X_START;
            wy0      <= win_y0 + Y_START;
            wy1      <= win_y1 + Y_START;
          end
        end
        S_LOAD: begin
          out_dc    <= ent_dc;
          out_data  <= ent_data;
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ent_cyc != 32'd0) begin
              // The LOAD cycle that follows WAIT is part of the delay gap.
              wait_cnt <= ent_cyc - 32'd1;
              state    <= S_WAIT;
            end else if (index == last_index) begin
              state <= S_DONE;
              busy  <= 1'b0;
              if (!win_mode) init_done <= 1'b1;
            end else begin
              index <= index + 5'd1;
              state <= S_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt <= 32'd1) begin
            if (index == last_index) begin
              state <= S_DONE;
              busy  <= 1'b0;
              if (!win_mode) init_done <= 1'b1;
            end else begin
              index <= index + 5'd1;
              state <= S_LOAD;
            end
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st7735s_init_sequencer.sv
// tb/tb_st7735s_init_sequencer.sv - directed bench for st7735s_init_sequencer
module tb_st7735s_init_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        win_req;
  logic [15:0] win_x0, win_x1, win_y0, win_y1;
  logic        out_valid;
  logic        out_ready;
  logic        out_dc;
  logic [7:0]  out_data;
  logic        busy;
  logic        init_done;
  logic [4:0]  seq_index;

  int total = 0;
  int bad   = 0;

  logic [8:0] words[$];
  int         gaps[$];
  int         low_run = 0;

  // {dc,byte} for WIDTH=160 HEIGHT=128 X_OFFSET=2 Y_OFFSET=1
  logic [8:0] init_exp [20] = '{
    9'h001, 9'h011, 9'h03A, 9'h106, 9'h036, 9'h160, 9'h020, 9'h013, 9'h02A, 9'h100,
    9'h102, 9'h100, 9'h1A1, 9'h02B, 9'h100, 9'h101, 9'h100, 9'h180, 9'h029, 9'h02C
  };
  // x0=10,x1=19,y0=0,y1=FFFF plus offsets 2/1: 000C 0015 0001 0000 (wrap)
  logic [8:0] win_exp [11] = '{
    9'h02A, 9'h100, 9'h10C, 9'h100, 9'h115, 9'h02B, 9'h100, 9'h101, 9'h100, 9'h100, 9'h02C
  };

  st7735s_init_sequencer #(
    .WIDTH(160), .HEIGHT(128), .X_OFFSET(2), .Y_OFFSET(1),
    .MADCTL_VAL(8'h60), .COLMOD_VAL(8'h06), .CLKS_PER_MS(4),
    .DLY_SWRESET_MS(2), .DLY_SLPOUT_MS(3), .DLY_DISPON_MS(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .win_req(win_req),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .out_valid(out_valid), .out_ready(out_ready), .out_dc(out_dc), .out_data(out_data),
    .busy(busy), .init_done(init_done), .seq_index(seq_index)
  );

  always #5 clk = ~clk;

  // Record every accepted word and the out_valid-low cycles preceding it.
  always @(posedge clk) begin
    if (out_valid) begin
      if (out_ready) begin
        words.push_back({out_dc, out_data});
        gaps.push_back(low_run);
        low_run = 0;
      end
    end else begin
      low_run = low_run + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k = 0;
    while (words.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(words.size()), 32'(n));
  endtask

  task automatic pulse(input logic s, input logic w);
    start   = s;
    win_req = w;
    @(negedge clk);
    start   = 1'b0;
    win_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_dc"},    32'(out_dc),    32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(init_done), 32'd0);
    check({tag, "_idx"},   32'(seq_index), 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; win_req = 1'b0; out_ready = 1'b1;
    win_x0 = 16'd10; win_x1 = 16'd19; win_y0 = 16'd0; win_y1 = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // win_req before any init is ignored
    pulse(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("idle_winreq_busy",  32'(busy), 32'd0);
    check("idle_winreq_valid", 32'(out_valid), 32'd0);
    check("idle_winreq_words", 32'(words.size()), 32'd0);

    // init run: latency, stall on entry 2, ignored start/win_req while busy
    words.delete(); gaps.delete();
    pulse(1'b1, 1'b0);
    check("lat_load_valid", 32'(out_valid), 32'd0);
    check("lat_load_busy",  32'(busy), 32'd1);
    @(negedge clk);
    check("lat_first_valid", 32'(out_valid), 32'd1);
    check("lat_first_word",  32'({out_dc, out_data}), 32'h001);

    k = 0;
    while (!(out_valid && seq_index == 5'd2) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_entry2", 32'(seq_index), 32'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_word", i), 32'({out_dc, out_data}), 32'h03A);
    end
    out_ready = 1'b1;

    wait_words(5, 200, "reach_word5");
    pulse(1'b1, 1'b1);
    wait_words(20, 500, "init_words");
    repeat (6) @(negedge clk);
    check("init_word_count", 32'(words.size()), 32'd20);
    check("init_done_set",   32'(init_done), 32'd1);
    check("init_busy_clear", 32'(busy), 32'd0);
    check("init_valid_low",  32'(out_valid), 32'd0);
    for (int i = 0; i < 20 && i < words.size(); i++)
      check($sformatf("init_w%0d", i), 32'(words[i]), 32'(init_exp[i]));
    if (gaps.size() >= 20) begin
      check("gap_swreset", 32'(gaps[1]), 32'd8);
      check("gap_slpout",  32'(gaps[2]), 32'd12);
      check("gap_nodelay", 32'(gaps[3]), 32'd1);
      check("gap_dispon",  32'(gaps[19]), 32'd4);
    end

    // runtime window with offsets and 16-bit wrap
    words.delete(); gaps.delete();
    pulse(1'b0, 1'b1);
    check("win_busy", 32'(busy), 32'd1);
    wait_words(11, 200, "win_words");
    repeat (4) @(negedge clk);
    check("win_word_count", 32'(words.size()), 32'd11);
    for (int i = 0; i < 11 && i < words.size(); i++)
      check($sformatf("win_w%0d", i), 32'(words[i]), 32'(win_exp[i]));
    check("win_init_done", 32'(init_done), 32'd1);
    check("win_busy_clear", 32'(busy), 32'd0);

    // start+win_req in DONE runs init; reset during SLPOUT wait aborts
    words.delete(); gaps.delete();
    pulse(1'b1, 1'b1);
    check("restart_done_clear", 32'(init_done), 32'd0);
    wait_words(2, 200, "restart_words");
    check("restart_w0", 32'(words[0]), 32'h001);
    check("restart_in_wait", 32'({busy, out_valid}), 32'b10);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_words", 32'(words.size()), 32'd2);

    // fresh start after abort begins at SWRESET
    words.delete(); gaps.delete();
    pulse(1'b1, 1'b0);
    wait_words(20, 500, "rerun_words");
    repeat (4) @(negedge clk);
    check("rerun_w0", 32'(words[0]), 32'h001);
    check("rerun_w19", 32'(words[19]), 32'h02C);
    check("rerun_done", 32'(init_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
